// File: rtl/visit_marker_pkg.sv
// Shared types and constants for the visit_marker vertex state tracker:
// operation codes, FSM states, stored-state bit positions and the mark update rule.
package visit_marker_pkg;

    typedef enum logic [1:0] {
        OP_VISIT = 2'b00,
        OP_CHECK = 2'b01,
        OP_READ  = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    localparam int CHECKED_BIT = 1;
    localparam int VISITED_BIT = 0;

    // New stored state for an operation; op 11 falls into the read-only default.
    function automatic logic [1:0] mark_update(input logic [1:0] old_mark, input logic [1:0] op);
        logic [1:0] upd;
        upd = old_mark;
        case (op)
            OP_VISIT: upd[VISITED_BIT] = 1'b1;
            OP_CHECK: upd[CHECKED_BIT] = 1'b1;
            default:  upd = old_mark;
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/visit_marker.sv
// Checked/visited marker: serialized read-modify-write of a 2-bit per-vertex state
// held in an external store with 2-cycle read latency, plus a full-store clear sweep.
module visit_marker
    import visit_marker_pkg::*;
#(
    parameter int PROC_BITS = 4,
    parameter int DEPTH     = 1024
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [32+PROC_BITS-1:0] req_vertex_in,
    input  logic [1:0]             req_op_in,
    input  logic                   req_valid_in,
    output logic                   req_ready_out,
    output logic [1:0]             resp_state_out,
    output logic                   resp_first_out,
    output logic                   resp_err_out,
    output logic                   resp_valid_out,
    input  logic                   clear_start_in,
    output logic                   clear_busy_out,
    output logic [32+PROC_BITS-1:0] idx_addr_out,
    output logic                   idx_valid_out,
    output logic [1:0]             write_data_out,
    output logic                   write_valid_out,
    input  logic [1:0]             bram3_in,
    input  logic                   bram3_valid_in
);

    localparam int VW = 32 + PROC_BITS;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [VW-1:0] DEPTH_V    = VW'(DEPTH);
    localparam logic [CW-1:0] CLR_LAST_V = CW'(DEPTH - 1);

    state_e          state_r;
    state_e          state_nx_s;
    logic [VW-1:0]   vertex_r;
    logic [1:0]      op_r;
    logic [1:0]      old_r;
    logic [1:0]      new_r;
    logic            err_r;
    logic [CW-1:0]   clr_addr_r;

    logic            accept_s;
    logic            in_range_s;
    logic            clr_last_s;
    logic [1:0]      wait_new_s;

    assign in_range_s = (req_vertex_in < DEPTH_V);
    assign clr_last_s = (clr_addr_r == CLR_LAST_V);
    assign wait_new_s = mark_update(bram3_in, op_r);
    // Clear has priority over a request presented in the same IDLE cycle.
    assign accept_s   = (state_r == ST_IDLE) & req_valid_in & ~clear_start_in;

    // State, request context, read-back latch and clear address registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= ST_CLEAR;
            vertex_r   <= {VW{1'b0}};
            op_r       <= 2'b00;
            old_r      <= 2'b00;
            new_r      <= 2'b00;
            err_r      <= 1'b0;
            clr_addr_r <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if ((state_r == ST_CLEAR) && (state_nx_s == ST_CLEAR)) begin
                clr_addr_r <= clr_addr_r + CW'(1);
            end else begin
                clr_addr_r <= {CW{1'b0}};
            end
            if (accept_s) begin
                vertex_r <= req_vertex_in;
                op_r     <= req_op_in;
                err_r    <= ~in_range_s;
                old_r    <= 2'b00;
                new_r    <= 2'b00;
            end else if ((state_r == ST_WAIT) && bram3_valid_in) begin
                old_r <= bram3_in;
                new_r <= wait_new_s;
            end else begin
                old_r <= old_r;
                new_r <= new_r;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (clear_start_in) begin
                    state_nx_s = ST_CLEAR;
                end else if (req_valid_in) begin
                    state_nx_s = in_range_s ? ST_READ : ST_RESP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_READ:  state_nx_s = ST_WAIT;
            ST_WAIT: begin
                if (bram3_valid_in) begin
                    state_nx_s = (wait_new_s != bram3_in) ? ST_WRITE : ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_WRITE: state_nx_s = ST_RESP;
            ST_RESP:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_CLEAR;
        endcase
    end

    // Output decode from the state register; reset forces everything but busy low,
    // which also hides the address-0 clear write while reset is held.
    always_comb begin
        req_ready_out   = 1'b0;
        resp_state_out  = 2'b00;
        resp_first_out  = 1'b0;
        resp_err_out    = 1'b0;
        resp_valid_out  = 1'b0;
        clear_busy_out  = 1'b0;
        idx_addr_out    = {VW{1'b0}};
        idx_valid_out   = 1'b0;
        write_data_out  = 2'b00;
        write_valid_out = 1'b0;
        if (rst_in) begin
            clear_busy_out = (state_r == ST_CLEAR);
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clear_busy_out  = 1'b1;
                    write_valid_out = 1'b1;
                    write_data_out  = 2'b00;
                    idx_addr_out    = VW'(clr_addr_r);
                end
                ST_IDLE: begin
                    req_ready_out = ~clear_start_in;
                end
                ST_READ: begin
                    idx_valid_out = 1'b1;
                    idx_addr_out  = vertex_r;
                end
                ST_WRITE: begin
                    write_valid_out = 1'b1;
                    write_data_out  = new_r;
                    idx_addr_out    = vertex_r;
                end
                ST_RESP: begin
                    resp_valid_out = 1'b1;
                    resp_state_out = old_r;
                    resp_first_out = (new_r != old_r);
                    resp_err_out   = err_r;
                end
                default: begin
                    req_ready_out = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_visit_marker.sv
// Self-checking bench for visit_marker: behavioural store with 2-cycle read latency,
// array reference model of per-vertex marks, directed and randomized scenarios.
module tb_visit_marker;

    localparam int DEPTH = 1024;
    localparam int VW    = 36;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [VW-1:0] req_vertex_in = '0;
    logic [1:0]    req_op_in = 2'b00;
    logic          req_valid_in = 1'b0;
    logic          req_ready_out;
    logic [1:0]    resp_state_out;
    logic          resp_first_out;
    logic          resp_err_out;
    logic          resp_valid_out;
    logic          clear_start_in = 1'b0;
    logic          clear_busy_out;
    logic [VW-1:0] idx_addr_out;
    logic          idx_valid_out;
    logic [1:0]    write_data_out;
    logic          write_valid_out;
    logic [1:0]    bram3_in;
    logic          bram3_valid_in;

    int checks = 0;
    int failures = 0;
    int overlap_cnt = 0;

    always #5 clk_in = ~clk_in;

    visit_marker #(.PROC_BITS(4), .DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_vertex_in(req_vertex_in), .req_op_in(req_op_in), .req_valid_in(req_valid_in),
        .req_ready_out(req_ready_out), .resp_state_out(resp_state_out),
        .resp_first_out(resp_first_out), .resp_err_out(resp_err_out),
        .resp_valid_out(resp_valid_out), .clear_start_in(clear_start_in),
        .clear_busy_out(clear_busy_out), .idx_addr_out(idx_addr_out),
        .idx_valid_out(idx_valid_out), .write_data_out(write_data_out),
        .write_valid_out(write_valid_out), .bram3_in(bram3_in), .bram3_valid_in(bram3_valid_in)
    );

    // Behavioural store: writes land at the edge, reads return two cycles after the strobe.
    logic [1:0]    mem [0:DEPTH-1];
    logic          scramble = 1'b0;
    logic          p1_v = 1'b0;
    logic [VW-1:0] p1_a = '0;
    logic          bram_v = 1'b0;
    logic [1:0]    bram_d = 2'b00;
    logic          spur = 1'b0;
    logic [1:0]    spur_d = 2'b00;

    always @(posedge clk_in) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'($urandom);
        end else if (write_valid_out && idx_addr_out < 36'd1024) begin
            mem[idx_addr_out[9:0]] <= write_data_out;
        end
        p1_v   <= idx_valid_out;
        p1_a   <= idx_addr_out;
        bram_v <= p1_v;
        bram_d <= (p1_a < 36'd1024) ? mem[p1_a[9:0]] : 2'b00;
    end

    assign bram3_valid_in = bram_v | spur;
    assign bram3_in       = spur ? spur_d : bram_d;

    always @(negedge clk_in) begin
        if (!rst_in && idx_valid_out && write_valid_out) overlap_cnt <= overlap_cnt + 1;
    end

    // Reference model: one 2-bit mark per vertex, updated by the operation rules.
    logic [1:0] model_mem [0:DEPTH-1];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 2'b00;
    endtask

    task automatic model_apply(input logic [VW-1:0] v, input logic [1:0] op,
                               output logic e_err, output logic [1:0] e_st, output logic e_first,
                               output logic [1:0] e_new, output int e_lat);
        logic [1:0] old;
        if (v >= 36'd1024) begin
            e_err = 1'b1; e_st = 2'b00; e_first = 1'b0; e_new = 2'b00; e_lat = 1;
        end else begin
            old = model_mem[v[9:0]];
            if (op == 2'b00)      e_new = old | 2'b01;
            else if (op == 2'b01) e_new = old | 2'b10;
            else                  e_new = old;
            e_err = 1'b0; e_st = old; e_first = (e_new != old);
            e_lat = e_first ? 5 : 4;
            model_mem[v[9:0]] = e_new;
        end
    endtask

    // Issue one request and observe the transaction up to its response.
    task automatic run_req(input logic [VW-1:0] v, input logic [1:0] op,
                           output logic to, output int lat, output logic [1:0] st,
                           output logic first, output logic err, output int n_idx,
                           output int n_wr, output logic [1:0] wdata, output int addr_bad);
        int n;
        logic got;
        to = 1'b0; lat = 0; st = 2'b00; first = 1'b0; err = 1'b0;
        n_idx = 0; n_wr = 0; wdata = 2'b00; addr_bad = 0; n = 0; got = 1'b0;
        @(negedge clk_in);
        while (!req_ready_out && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 3000) begin
            to = 1'b1;
            return;
        end
        req_vertex_in = v; req_op_in = op; req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk_in);
            if (idx_valid_out) begin
                n_idx++;
                if (idx_addr_out !== v) addr_bad++;
            end
            if (write_valid_out) begin
                n_wr++;
                wdata = write_data_out;
                if (idx_addr_out !== v) addr_bad++;
            end
            if (resp_valid_out) begin
                got = 1'b1; lat = c; st = resp_state_out;
                first = resp_first_out; err = resp_err_out;
            end
        end
        if (!got) to = 1'b1;
    endtask

    // Observe a clear sweep from its first cycle until busy drops.
    task automatic observe_sweep(output int cnt, output int bad);
        cnt = 0; bad = 0;
        @(negedge clk_in);
        while (clear_busy_out && cnt < 3000) begin
            if (!(write_valid_out && !idx_valid_out && idx_addr_out == VW'(cnt) &&
                  write_data_out == 2'b00 && !req_ready_out && !resp_valid_out)) bad++;
            cnt++;
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset();
        int cnt, bad, nz;
        @(negedge clk_in);
        scramble = 1'b1;
        @(negedge clk_in);
        scramble = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++;
        if ({req_ready_out, resp_valid_out, idx_valid_out, write_valid_out, resp_err_out,
             resp_first_out, resp_state_out, write_data_out} !== 10'b0 || idx_addr_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b iv=%b wv=%b addr=%0h required all zero",
                     req_ready_out, resp_valid_out, idx_valid_out, write_valid_out, idx_addr_out);
        end
        checks++;
        if (clear_busy_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy: got %b required 1", clear_busy_out);
        end
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        observe_sweep(cnt, bad);
        checks++;
        if (cnt != DEPTH || bad != 0) begin
            failures++;
            $display("FAIL reset_sweep: got %0d cycles %0d bad required %0d cycles 0 bad", cnt, bad, DEPTH);
        end
        checks++;
        if (req_ready_out !== 1'b1 || clear_busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got rdy=%b busy=%b required 1 0", req_ready_out, clear_busy_out);
        end
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 2'b00) nz++;
        checks++;
        if (nz != 0) begin
            failures++;
            $display("FAIL reset_store_zero: got %0d nonzero entries required 0", nz);
        end
        model_clear();
    endtask

    task automatic test_visit();
        logic [1:0] t_op [4]    = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic [1:0] t_st [4]    = '{2'b00, 2'b01, 2'b01, 2'b11};
        logic       t_first [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int         t_lat [4]   = '{5, 4, 5, 4};
        logic [1:0] t_wd [4]    = '{2'b01, 2'b00, 2'b11, 2'b00};
        logic to, first, err, e_err, e_first;
        logic [1:0] st, wdata, e_st, e_new;
        int lat, n_idx, n_wr, addr_bad, e_lat;
        for (int i = 0; i < 4; i++) begin
            model_apply(36'd5, t_op[i], e_err, e_st, e_first, e_new, e_lat);
            run_req(36'd5, t_op[i], to, lat, st, first, err, n_idx, n_wr, wdata, addr_bad);
            checks++;
            if (to || err !== 1'b0 || st !== t_st[i] || first !== t_first[i]) begin
                failures++;
                $display("FAIL visit_resp[%0d]: got to=%b err=%b st=%b first=%b required 0 0 %b %b",
                         i, to, err, st, first, t_st[i], t_first[i]);
            end
            checks++;
            if (lat != t_lat[i] || n_idx != 1 || n_wr != (t_first[i] ? 1 : 0) || addr_bad != 0) begin
                failures++;
                $display("FAIL visit_timing[%0d]: got lat=%0d idx=%0d wr=%0d badaddr=%0d required lat=%0d idx=1 wr=%0d",
                         i, lat, n_idx, n_wr, addr_bad, t_lat[i], t_first[i] ? 1 : 0);
            end
            if (t_first[i]) begin
                checks++;
                if (wdata !== t_wd[i]) begin
                    failures++;
                    $display("FAIL visit_wdata[%0d]: got %b required %b", i, wdata, t_wd[i]);
                end
            end
        end
    endtask

    task automatic test_error();
        logic [VW-1:0] t_v [2] = '{36'd1024, 36'hF_FFFF_FFFF};
        logic to, first, err, e_err, e_first;
        logic [1:0] st, wdata, e_st, e_new;
        int lat, n_idx, n_wr, addr_bad, e_lat;
        for (int i = 0; i < 2; i++) begin
            model_apply(t_v[i], 2'(i), e_err, e_st, e_first, e_new, e_lat);
            run_req(t_v[i], 2'(i), to, lat, st, first, err, n_idx, n_wr, wdata, addr_bad);
            checks++;
            if (to || err !== 1'b1 || st !== 2'b00 || first !== 1'b0 || lat != 1 || n_idx != 0 || n_wr != 0) begin
                failures++;
                $display("FAIL error_resp[%0d]: got to=%b err=%b st=%b first=%b lat=%0d idx=%0d wr=%0d required err=1 st=00 first=0 lat=1 no access",
                         i, to, err, st, first, lat, n_idx, n_wr);
            end
        end
    endtask

    task automatic test_spurious();
        logic to, first, err, e_err, e_first;
        logic [1:0] st, wdata, e_st, e_new;
        int lat, n_idx, n_wr, addr_bad, e_lat;
        @(negedge clk_in);
        spur = 1'b1; spur_d = 2'b11;
        @(negedge clk_in);
        spur = 1'b0;
        checks++;
        if (resp_valid_out !== 1'b0 || req_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL spurious_idle: got rv=%b rdy=%b required 0 1", resp_valid_out, req_ready_out);
        end
        model_apply(36'd7, 2'b10, e_err, e_st, e_first, e_new, e_lat);
        run_req(36'd7, 2'b10, to, lat, st, first, err, n_idx, n_wr, wdata, addr_bad);
        checks++;
        if (to || st !== 2'b00 || first !== 1'b0 || lat != 4) begin
            failures++;
            $display("FAIL spurious_read: got to=%b st=%b first=%b lat=%0d required 0 00 0 4", to, st, first, lat);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] v;
        logic [1:0] op;
        int sel;
        logic to, first, err, e_err, e_first;
        logic [1:0] st, wdata, e_st, e_new;
        int lat, n_idx, n_wr, addr_bad, e_lat;
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      v = {4'($urandom), $urandom};
            else if (sel == 1) v = 36'd1024 + 36'($urandom_range(0, 3));
            else if (sel <= 3) v = 36'(1020 + $urandom_range(0, 3));
            else               v = 36'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
            model_apply(v, op, e_err, e_st, e_first, e_new, e_lat);
            run_req(v, op, to, lat, st, first, err, n_idx, n_wr, wdata, addr_bad);
            checks++;
            if (to) begin
                failures++;
                $display("FAIL rand_timeout[%0d]: got no response required one (v=%0h op=%b)", k, v, op);
            end else begin
                if ({err, st, first} !== {e_err, e_st, e_first}) begin
                    failures++;
                    $display("FAIL rand_resp[%0d]: v=%0h op=%b got err=%b st=%b first=%b required %b %b %b",
                             k, v, op, err, st, first, e_err, e_st, e_first);
                end
                checks++;
                if (lat != e_lat || n_idx != (e_err ? 0 : 1) || n_wr != (e_first ? 1 : 0) || addr_bad != 0) begin
                    failures++;
                    $display("FAIL rand_timing[%0d]: got lat=%0d idx=%0d wr=%0d badaddr=%0d required lat=%0d idx=%0d wr=%0d",
                             k, lat, n_idx, n_wr, addr_bad, e_lat, e_err ? 0 : 1, e_first ? 1 : 0);
                end
                if (e_first) begin
                    checks++;
                    if (wdata !== e_new) begin
                        failures++;
                        $display("FAIL rand_wdata[%0d]: got %b required %b", k, wdata, e_new);
                    end
                end
            end
        end
    endtask

    task automatic test_clear_race();
        int cnt, bad, n;
        logic to, first, err;
        logic [1:0] st, wdata;
        int lat, n_idx, n_wr, addr_bad;
        n = 0;
        @(negedge clk_in);
        while (!req_ready_out && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        clear_start_in = 1'b1; req_valid_in = 1'b1; req_vertex_in = 36'd5; req_op_in = 2'b00;
        #1;
        checks++;
        if (req_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL race_ready: got %b required 0", req_ready_out);
        end
        @(posedge clk_in);
        #1 clear_start_in = 1'b0; req_valid_in = 1'b0;
        observe_sweep(cnt, bad);
        checks++;
        if (cnt != DEPTH || bad != 0 || req_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL race_sweep: got %0d cycles %0d bad rdy=%b required %0d cycles 0 bad rdy=1",
                     cnt, bad, req_ready_out, DEPTH);
        end
        model_clear();
        run_req(36'd5, 2'b10, to, lat, st, first, err, n_idx, n_wr, wdata, addr_bad);
        checks++;
        if (to || st !== 2'b00 || first !== 1'b0 || err !== 1'b0 || lat != 4) begin
            failures++;
            $display("FAIL race_after: got to=%b st=%b first=%b err=%b lat=%0d required 0 00 0 0 4",
                     to, st, first, err, lat);
        end
    endtask

    task automatic test_reset_mid();
        int cnt, bad, n, rv_seen;
        logic to, first, err, e_err, e_first;
        logic [1:0] st, wdata, e_st, e_new;
        int lat, n_idx, n_wr, addr_bad, e_lat;
        model_apply(36'd9, 2'b00, e_err, e_st, e_first, e_new, e_lat);
        run_req(36'd9, 2'b00, to, lat, st, first, err, n_idx, n_wr, wdata, addr_bad);
        n = 0;
        @(negedge clk_in);
        while (!req_ready_out && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        req_vertex_in = 36'd9; req_op_in = 2'b01; req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (idx_valid_out !== 1'b1 || idx_addr_out !== 36'd9) begin
            failures++;
            $display("FAIL mid_read: got iv=%b addr=%0h required 1 9", idx_valid_out, idx_addr_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_in);
            if (resp_valid_out || idx_valid_out) rv_seen++;
        end
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        observe_sweep(cnt, bad);
        checks++;
        if (rv_seen != 0 || cnt != DEPTH || bad != 0) begin
            failures++;
            $display("FAIL mid_reset_sweep: got resp=%0d cycles=%0d bad=%0d required 0 %0d 0",
                     rv_seen, cnt, bad, DEPTH);
        end
        model_clear();
        run_req(36'd9, 2'b10, to, lat, st, first, err, n_idx, n_wr, wdata, addr_bad);
        checks++;
        if (to || st !== 2'b00 || first !== 1'b0 || lat != 4) begin
            failures++;
            $display("FAIL mid_after: got to=%b st=%b first=%b lat=%0d required 0 00 0 4", to, st, first, lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_visit();
        test_error();
        test_spurious();
        test_random();
        test_clear_race();
        test_reset_mid();
        repeat (2) @(negedge clk_in);
        checks++;
        if (overlap_cnt != 0) begin
            failures++;
            $display("FAIL strobe_overlap: got %0d cycles with read and write strobes together required 0", overlap_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
